// File: rtl/pair_match_scorer.sv
// Pair-equality window scorer; optional self-compare checking via PAIR_MATCH_DIAG_EN.
// Result valid 1 cycle after the last beat of a window; input stalls (in_ready=0) while the result is held.
module pair_match_scorer #(
   parameter int WINDOW = 4
) (
   input  logic        clk,
   input  logic        areset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [24:0] eq_vec,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  score_sum,
   output logic [3:0]  full_match_cnt,
   output logic        diag_err
);

   typedef enum logic {ACCUM, HOLD} state_t;

   localparam logic [3:0] LAST_BEAT = 4'(WINDOW - 1);

   state_t     state, state_nxt;
   logic [3:0] beat_cnt;
   logic [7:0] acc_sum;
   logic [3:0] acc_full;
   logic       accept;
   logic       release_res;

   function automatic logic [4:0] popcount25(input logic [24:0] v);
      logic [4:0] n;
      n = 5'd0;
      for (int i = 0; i < 25; i++) n = n + {4'd0, v[i]};
      return n;
   endfunction

   always_ff @(posedge clk or posedge areset) begin
      if (areset) state <= ACCUM;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && beat_cnt == LAST_BEAT) state_nxt = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
   end

   assign accept      = in_valid && in_ready;
   assign release_res = out_valid && out_ready;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         beat_cnt <= 4'd0;
         acc_sum  <= 8'd0;
         acc_full <= 4'd0;
      end else if (release_res) begin
         beat_cnt <= 4'd0;
         acc_sum  <= 8'd0;
         acc_full <= 4'd0;
      end else if (accept) begin
         beat_cnt <= beat_cnt + 4'd1;
         acc_sum  <= acc_sum + {3'd0, popcount25(eq_vec)};
         acc_full <= acc_full + {3'd0, &eq_vec};
      end
   end

   // Accumulators are only exposed while the result is presented.
   assign score_sum      = out_valid ? acc_sum  : 8'd0;
   assign full_match_cnt = out_valid ? acc_full : 4'd0;

`ifdef PAIR_MATCH_DIAG_EN
   logic diag_q;
   // Self-compare bits (a~^a .. e~^e) must always read 1 for a well-formed vector.
   always_ff @(posedge clk or posedge areset) begin
      if (areset)
         diag_q <= 1'b0;
      else if (accept && !(&{eq_vec[24], eq_vec[18], eq_vec[12], eq_vec[6], eq_vec[0]}))
         diag_q <= 1'b1;
   end
   assign diag_err = diag_q;
`else
   assign diag_err = 1'b0;
`endif

endmodule

// File: tb/tb_pair_match_scorer.sv
// Directed bench for pair_match_scorer: one WINDOW=4 instance and one WINDOW=3 instance.
module tb_pair_match_scorer;

   logic        clk = 1'b0;
   logic        areset = 1'b1;

   logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, diag4;
   logic [24:0] eq_vec4 = 25'd0;
   logic [7:0]  sum4;
   logic [3:0]  full4;

   logic        in_valid3 = 1'b0, in_ready3, out_valid3, out_ready3 = 1'b0, diag3;
   logic [24:0] eq_vec3 = 25'd0;
   logic [7:0]  sum3;
   logic [3:0]  full3;

   int n_checks = 0;
   int n_errors = 0;

   logic [24:0] all_ones, v17, v13;
   logic        diag_exp;

   pair_match_scorer #(.WINDOW(4)) dut4 (
      .clk(clk), .areset(areset), .in_valid(in_valid4), .in_ready(in_ready4),
      .eq_vec(eq_vec4), .out_valid(out_valid4), .out_ready(out_ready4),
      .score_sum(sum4), .full_match_cnt(full4), .diag_err(diag4)
   );

   pair_match_scorer #(.WINDOW(3)) dut3 (
      .clk(clk), .areset(areset), .in_valid(in_valid3), .in_ready(in_ready3),
      .eq_vec(eq_vec3), .out_valid(out_valid3), .out_ready(out_ready3),
      .score_sum(sum3), .full_match_cnt(full3), .diag_err(diag3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // x = {a,b,c,d,e}; bit 24-(5*i+j) holds input_i ~^ input_j.
   function automatic logic [24:0] mk_vec(input logic [4:0] x);
      logic [24:0] v;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++)
            v[24 - (5 * i + j)] = ~(x[4 - i] ^ x[4 - j]);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beats4(input logic [24:0] v, input int n);
      for (int k = 0; k < n; k++) begin
         in_valid4 = 1'b1;
         eq_vec4   = v;
         tick();
      end
      in_valid4 = 1'b0;
   endtask

   task automatic consume4();
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
   endtask

   initial begin
      all_ones = 25'h1FFFFFF;
      v17      = mk_vec(5'b10000);
      v13      = mk_vec(5'b11000);
`ifdef PAIR_MATCH_DIAG_EN
      diag_exp = 1'b1;
`else
      diag_exp = 1'b0;
`endif

      // Reset state
      tick();
      tick();
      areset = 1'b0;
      tick();
      check("rst_in_ready", in_ready4, 1);
      check("rst_out_valid", out_valid4, 0);
      check("rst_sum", sum4, 0);
      check("rst_full", full4, 0);
      check("rst_diag", diag4, 0);

      // Four all-ones beats
      beats4(all_ones, 3);
      check("ones_not_early", out_valid4, 0);
      beats4(all_ones, 1);
      check("ones_out_valid", out_valid4, 1);
      check("ones_in_ready", in_ready4, 0);
      check("ones_sum", sum4, 100);
      check("ones_full", full4, 4);

      // Stall in HOLD with in_valid asserted
      in_valid4 = 1'b1;
      eq_vec4   = all_ones;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("stall_out_valid", out_valid4, 1);
         check("stall_in_ready", in_ready4, 0);
         check("stall_sum", sum4, 100);
         check("stall_full", full4, 4);
      end
      in_valid4 = 1'b0;
      consume4();
      check("rel_in_ready", in_ready4, 1);
      check("rel_out_valid", out_valid4, 0);
      check("rel_sum", sum4, 0);
      check("rel_full", full4, 0);

      // a=1, others 0: popcount 17 per beat; also shows no stalled beat leaked in
      beats4(v17, 4);
      check("p17_out_valid", out_valid4, 1);
      check("p17_sum", sum4, 68);
      check("p17_full", full4, 0);
      consume4();

      // Reset mid-window discards partial beats
      beats4(all_ones, 2);
      #2 areset = 1'b1;
      #2 areset = 1'b0;
      tick();
      check("midrst_in_ready", in_ready4, 1);
      check("midrst_out_valid", out_valid4, 0);
      beats4(all_ones, 3);
      check("midrst_not_early", out_valid4, 0);
      beats4(all_ones, 1);
      check("midrst_out_valid2", out_valid4, 1);
      check("midrst_sum", sum4, 100);
      check("midrst_full", full4, 4);

      // Reset during HOLD drops the pending result
      #2 areset = 1'b1;
      #2 areset = 1'b0;
      tick();
      check("holdrst_out_valid", out_valid4, 0);
      check("holdrst_sum", sum4, 0);

      // Malformed beat (self-compare bits 0) then later window
      beats4(25'd0, 1);
      check("diag_set", diag4, 32'(diag_exp));
      beats4(all_ones, 3);
      check("diag_win_sum", sum4, 75);
      check("diag_win_full", full4, 3);
      consume4();
      beats4(v13, 4);
      check("diag_sticky", diag4, 32'(diag_exp));
      check("p13_sum", sum4, 52);
      consume4();
      check("diag_sticky2", diag4, 32'(diag_exp));
      #2 areset = 1'b1;
      #2 areset = 1'b0;
      tick();
      check("diag_cleared", diag4, 0);

      // WINDOW=3 with in_valid toggling every other cycle
      in_valid3 = 1'b1; eq_vec3 = all_ones; tick();
      in_valid3 = 1'b0; eq_vec3 = 25'd0;    tick();
      in_valid3 = 1'b1; eq_vec3 = v17;      tick();
      in_valid3 = 1'b0; eq_vec3 = 25'd0;    tick();
      check("w3_not_early", out_valid3, 0);
      in_valid3 = 1'b1; eq_vec3 = v13;      tick();
      in_valid3 = 1'b0;
      check("w3_out_valid", out_valid3, 1);
      check("w3_sum", sum3, 55);
      check("w3_full", full3, 1);
      check("w3_diag", diag3, 0);
      out_ready3 = 1'b1;
      tick();
      out_ready3 = 1'b0;
      check("w3_rel_in_ready", in_ready3, 1);
      check("w3_rel_sum", sum3, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
